// File: rtl/periph_pkg.sv
// Shared constants for the memory-mapped timer/IO peripheral:
// register byte offsets and TCON bit positions.
package periph_pkg;

  localparam logic [4:0] OFS_TH      = 5'h00;
  localparam logic [4:0] OFS_TL      = 5'h04;
  localparam logic [4:0] OFS_TCON    = 5'h08;
  localparam logic [4:0] OFS_LED     = 5'h0C;
  localparam logic [4:0] OFS_SW      = 5'h10;
  localparam logic [4:0] OFS_DIGI    = 5'h14;
  localparam logic [4:0] OFS_SYSTICK = 5'h18;

  localparam int TCON_EN = 0;
  localparam int TCON_IE = 1;
  localparam int TCON_IS = 2;

endpackage

// File: rtl/peripheral_timer_if.sv
// CPU data bus as seen by the peripheral window:
// read/write strobes, address, write data and read data.
interface peripheral_timer_if;

  logic        MemRd;
  logic        MemWr;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  modport master (
    output MemRd, MemWr, Address, WriteData,
    input  ReadData
  );

  modport slave (
    input  MemRd, MemWr, Address, WriteData,
    output ReadData
  );

endinterface

// File: rtl/periph_timer_core.sv
// TH/TL/TCON timer: TL counts up, reloads from TH on overflow,
// and latches the interrupt status bit when enabled.
module periph_timer_core
  import periph_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        we_th,
  input  logic        we_tl,
  input  logic        we_tcon,
  input  logic [31:0] wdata,
  output logic [31:0] th,
  output logic [31:0] tl,
  output logic [2:0]  tcon,
  output logic        irq
);

  logic ovf;
  logic set_is;

  assign ovf    = tcon[TCON_EN] && (tl == 32'hFFFF_FFFF);
  assign set_is = ovf && tcon[TCON_IE];
  assign irq    = tcon[TCON_IE] & tcon[TCON_IS];

  // Reload register; an overflow in the same cycle uses the old value
  always_ff @(posedge clk) begin
    if (reset)      th <= '0;
    else if (we_th) th <= wdata;
  end

  // Counter: CPU write beats increment and reload
  always_ff @(posedge clk) begin
    if (reset)                tl <= '0;
    else if (we_tl)           tl <= wdata;
    else if (ovf)             tl <= th;
    else if (tcon[TCON_EN])   tl <= tl + 32'd1;
  end

  // Control/status; a write during overflow still keeps the new interrupt
  always_ff @(posedge clk) begin
    if (reset)        tcon <= '0;
    else if (we_tcon) tcon <= wdata[2:0] | {set_is, 2'b00};
    else if (set_is)  tcon[TCON_IS] <= 1'b1;
  end

endmodule

// File: rtl/peripheral_timer.sv
// Timer/IO peripheral at BASE_ADDR: timer, LED, switch, 7-seg regs.
// Optional free-running systick at 0x18 when PERIPH_SYSTICK_EN is defined.
module peripheral_timer
  import periph_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0000,
  parameter int          LED_W     = 8
) (
  input  logic             clk,
  input  logic             reset,
  peripheral_timer_if.slave bus,
  input  logic [LED_W-1:0] switch,
  output logic [LED_W-1:0] led,
  output logic [11:0]      digi,
  output logic             IRQ
);

  logic        sel;
  logic        wr;
  logic [4:0]  ofs;
  logic [31:0] th;
  logic [31:0] tl;
  logic [2:0]  tcon;
  logic [31:0] rdata;
  logic [LED_W-1:0] sw_s1;
  logic [LED_W-1:0] sw_s2;
  logic        unused_addr;

  assign sel = bus.Address[31:5] == BASE_ADDR[31:5];
  assign ofs = {bus.Address[4:2], 2'b00};
  assign wr  = bus.MemWr & sel;

  assign unused_addr = ^bus.Address[1:0];

  periph_timer_core u_core (
    .clk     (clk),
    .reset   (reset),
    .we_th   (wr && ofs == OFS_TH),
    .we_tl   (wr && ofs == OFS_TL),
    .we_tcon (wr && ofs == OFS_TCON),
    .wdata   (bus.WriteData),
    .th      (th),
    .tl      (tl),
    .tcon    (tcon),
    .irq     (IRQ)
  );

  // Output registers written from the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      led  <= '0;
      digi <= '0;
    end else begin
      if (wr && ofs == OFS_LED)  led  <= bus.WriteData[LED_W-1:0];
      if (wr && ofs == OFS_DIGI) digi <= bus.WriteData[11:0];
    end
  end

  // Two-flop synchronizer for the asynchronous board switches
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_s1 <= '0;
      sw_s2 <= '0;
    end else begin
      sw_s1 <= switch;
      sw_s2 <= sw_s1;
    end
  end

`ifdef PERIPH_SYSTICK_EN
  logic [31:0] systick;

  // Free-running cycle counter, wraps naturally
  always_ff @(posedge clk) begin
    if (reset) systick <= '0;
    else       systick <= systick + 32'd1;
  end
`endif

  // Combinational read mux; zero unless a mapped read is in progress
  always_comb begin
    rdata = '0;
    if (bus.MemRd && sel) begin
      case (ofs)
        OFS_TH:      rdata = th;
        OFS_TL:      rdata = tl;
        OFS_TCON:    rdata = {29'd0, tcon};
        OFS_LED:     rdata = {{(32-LED_W){1'b0}}, led};
        OFS_SW:      rdata = {{(32-LED_W){1'b0}}, sw_s2};
        OFS_DIGI:    rdata = {20'd0, digi};
`ifdef PERIPH_SYSTICK_EN
        OFS_SYSTICK: rdata = systick;
`endif
        default:     rdata = '0;
      endcase
    end
  end

  assign bus.ReadData = rdata;

endmodule

// File: tb/tb_peripheral_timer.sv
// Directed self-checking bench for peripheral_timer:
// reset, overflow/reload, IRQ, bus collisions, IO regs, systick.
module tb_peripheral_timer;

  localparam logic [31:0] B = 32'h4000_0000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] switch = 8'h00;
  logic [7:0] led;
  logic [11:0] digi;
  logic       IRQ;

  int n_cmp = 0;
  int n_err = 0;

  peripheral_timer_if bus ();

  peripheral_timer #(
    .BASE_ADDR (B),
    .LED_W     (8)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .switch (switch),
    .led    (led),
    .digi   (digi),
    .IRQ    (IRQ)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout want finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.MemWr     = 1'b1;
    bus.Address   = a;
    bus.WriteData = d;
    tick();
    bus.MemWr     = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.MemRd   = 1'b1;
    bus.Address = a;
    #1;
    d = bus.ReadData;
    bus.MemRd   = 1'b0;
  endtask

  task automatic test_reset();
    logic [31:0] d;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 8; i++) begin
      rd(B + 32'(i * 4), d);
      n_cmp++;
      if (d !== 32'd0) begin
        $display("FAIL reset_rd ofs=%0h got %h want 0", i * 4, d);
        n_err++;
      end
    end
    n_cmp++;
    if (IRQ !== 1'b0) begin
      $display("FAIL reset_irq got %b want 0", IRQ);
      n_err++;
    end
    n_cmp++;
    if (led !== 8'h00 || digi !== 12'h000) begin
      $display("FAIL reset_io got %h/%h want 0/0", led, digi);
      n_err++;
    end
    n_cmp++;
    if (bus.ReadData !== 32'd0) begin
      $display("FAIL idle_rdata got %h want 0", bus.ReadData);
      n_err++;
    end
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    wr(B + 32'h00, 32'hFFFF_FFFC);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'h0000_0003);
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFE) begin
      $display("FAIL ovf_tl0 got %h want FFFFFFFE", d);
      n_err++;
    end
    tick();
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFF || IRQ !== 1'b0) begin
      $display("FAIL ovf_tl1 got %h irq %b want FFFFFFFF irq 0", d, IRQ);
      n_err++;
    end
    tick();
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFC) begin
      $display("FAIL ovf_reload got %h want FFFFFFFC", d);
      n_err++;
    end
    n_cmp++;
    if (IRQ !== 1'b1) begin
      $display("FAIL ovf_irq got %b want 1", IRQ);
      n_err++;
    end
    rd(B + 32'h08, d);
    n_cmp++;
    if (d !== 32'd7) begin
      $display("FAIL ovf_tcon got %h want 7", d);
      n_err++;
    end
  endtask

  task automatic test_irq_clear();
    logic [31:0] d;
    wr(B + 32'h08, 32'd1);
    n_cmp++;
    if (IRQ !== 1'b0) begin
      $display("FAIL clr_irq got %b want 0", IRQ);
      n_err++;
    end
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'hFFFF_FFFD) begin
      $display("FAIL clr_count got %h want FFFFFFFD", d);
      n_err++;
    end
    wr(B + 32'h08, 32'd3);
    tick();
    n_cmp++;
    if (IRQ !== 1'b0) begin
      $display("FAIL rearm_pre got %b want 0", IRQ);
      n_err++;
    end
    tick();
    n_cmp++;
    if (IRQ !== 1'b1) begin
      $display("FAIL rearm_irq got %b want 1", IRQ);
      n_err++;
    end
  endtask

  task automatic test_no_ie();
    logic [31:0] d;
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFF);
    wr(B + 32'h00, 32'h0000_0010);
    wr(B + 32'h08, 32'd1);
    tick();
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'h10) begin
      $display("FAIL noie_reload got %h want 10", d);
      n_err++;
    end
    rd(B + 32'h08, d);
    n_cmp++;
    if (d !== 32'd1 || IRQ !== 1'b0) begin
      $display("FAIL noie_tcon got %h irq %b want 1 irq 0", d, IRQ);
      n_err++;
    end
  endtask

  task automatic test_collide();
    logic [31:0] d;
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd3);
    tick();
    wr(B + 32'h08, 32'd3);
    rd(B + 32'h08, d);
    n_cmp++;
    if (d !== 32'd7 || IRQ !== 1'b1) begin
      $display("FAIL col_tcon got %h irq %b want 7 irq 1", d, IRQ);
      n_err++;
    end
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'h10) begin
      $display("FAIL col_tcon_tl got %h want 10", d);
      n_err++;
    end
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd1);
    tick();
    wr(B + 32'h04, 32'd5);
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'd5) begin
      $display("FAIL col_tl got %h want 5", d);
      n_err++;
    end
    wr(B + 32'h08, 32'd0);
    wr(B + 32'h04, 32'hFFFF_FFFE);
    wr(B + 32'h08, 32'd1);
    tick();
    wr(B + 32'h00, 32'h77);
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'h10) begin
      $display("FAIL col_th_reload got %h want 10", d);
      n_err++;
    end
    rd(B + 32'h00, d);
    n_cmp++;
    if (d !== 32'h77) begin
      $display("FAIL col_th got %h want 77", d);
      n_err++;
    end
  endtask

  task automatic test_rdwr();
    logic [31:0] d;
    wr(B + 32'h08, 32'd0);
    bus.MemRd     = 1'b1;
    bus.MemWr     = 1'b1;
    bus.Address   = B + 32'h00;
    bus.WriteData = 32'h99;
    #1;
    n_cmp++;
    if (bus.ReadData !== 32'h77) begin
      $display("FAIL rdwr_pre got %h want 77", bus.ReadData);
      n_err++;
    end
    tick();
    bus.MemRd = 1'b0;
    bus.MemWr = 1'b0;
    rd(B + 32'h00, d);
    n_cmp++;
    if (d !== 32'h99) begin
      $display("FAIL rdwr_post got %h want 99", d);
      n_err++;
    end
    wr(B + 32'h10, 32'hFF);
    wr(32'h5000_0000, 32'h1234);
    wr(B + 32'h1C, 32'h1234);
    rd(B + 32'h10, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL ro_sw got %h want 0", d);
      n_err++;
    end
    rd(B + 32'h00, d);
    n_cmp++;
    if (d !== 32'h99) begin
      $display("FAIL unmapped_wr got %h want 99", d);
      n_err++;
    end
    rd(B + 32'h1C, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL unmapped_rd got %h want 0", d);
      n_err++;
    end
  endtask

  task automatic test_io();
    logic [31:0] d;
    logic [31:0] a;
    switch = 8'hA5;
    tick();
    rd(B + 32'h10, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL sw_lat1 got %h want 0", d);
      n_err++;
    end
    tick();
    rd(B + 32'h10, d);
    n_cmp++;
    if (d !== 32'hA5) begin
      $display("FAIL sw_lat2 got %h want A5", d);
      n_err++;
    end
    wr(B + 32'h0C, 32'h5A);
    wr(B + 32'h14, 32'h3FF);
    n_cmp++;
    if (led !== 8'h5A) begin
      $display("FAIL led got %h want 5A", led);
      n_err++;
    end
    n_cmp++;
    if (digi !== 12'h3FF) begin
      $display("FAIL digi got %h want 3FF", digi);
      n_err++;
    end
    rd(B + 32'h14, d);
    n_cmp++;
    if (d !== 32'h3FF) begin
      $display("FAIL digi_rd got %h want 3FF", d);
      n_err++;
    end
    rd(B + 32'h18, a);
    repeat (5) tick();
    rd(B + 32'h18, d);
`ifdef PERIPH_SYSTICK_EN
    n_cmp++;
    if (d - a !== 32'd5) begin
      $display("FAIL systick_delta got %0d want 5", d - a);
      n_err++;
    end
`else
    n_cmp++;
    if ((d | a) !== 32'd0) begin
      $display("FAIL systick_off got %h/%h want 0", a, d);
      n_err++;
    end
`endif
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    wr(B + 32'h04, 32'hFFFF_FFFF);
    wr(B + 32'h08, 32'd3);
    tick();
    n_cmp++;
    if (IRQ !== 1'b1) begin
      $display("FAIL mid_pre_irq got %b want 1", IRQ);
      n_err++;
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (IRQ !== 1'b0 || led !== 8'h00 || digi !== 12'h000) begin
      $display("FAIL mid_reset_io got %b/%h/%h want 0/0/0", IRQ, led, digi);
      n_err++;
    end
    rd(B + 32'h04, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL mid_reset_tl got %h want 0", d);
      n_err++;
    end
    rd(B + 32'h08, d);
    n_cmp++;
    if (d !== 32'd0) begin
      $display("FAIL mid_reset_tcon got %h want 0", d);
      n_err++;
    end
  endtask

  initial begin
    bus.MemRd     = 1'b0;
    bus.MemWr     = 1'b0;
    bus.Address   = '0;
    bus.WriteData = '0;
    tick();
    test_reset();
    test_overflow();
    test_irq_clear();
    test_no_ie();
    test_collide();
    test_rdwr();
    test_io();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
